top: RTL and testbench

- Registered N-bit approximate adder using the OLOCA scheme (OR-based Lower-part, Constant Approximation).
- The lower L bits are approximated: the K least-significant bits are forced to 1, and the remaining lower bits are a bitwise OR of the operands.
- The upper N-L bits are added exactly, producing an (N+1)-bit sum.
- Used as the datapath adder under evaluation in the approximate-arithmetic error-analysis environment; the error is measured externally against the exact A+B.

---
 rtl/top.sv | 69 ++++++
 tb/tb_top.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Registered OLOCA approximate adder: constant-one LSBs, OR-based lower part, exact upper part.
// Optional macro OLOCA_CARRY_EN enables LOA-style carry-in a[L-1] & b[L-1] into the upper part.
module top #(
    parameter int N = 16,
    parameter int L = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N:0]   result
);

    localparam int UW = N - L + 1;

    logic [N:0] result_d;
    logic [N:0] result_q;
    logic       out_valid_q;
    logic       carry_in;

    generate
        if (K > L || L > N || K < 0) begin : g_bad_params
            $error("top: illegal parameters, need 0 <= K <= L <= N (N=%0d L=%0d K=%0d)", N, L, K);
        end

        if (L > 0) begin : g_lower
`ifdef OLOCA_CARRY_EN
            assign carry_in = a[L-1] & b[L-1];
`else
            assign carry_in = 1'b0;
`endif
            // Constant bits are literals, so they stay 1 even when the operands are X.
            if (K > 0) begin : g_const
                assign result_d[K-1:0] = '1;
            end
            if (L > K) begin : g_or
                assign result_d[L-1:K] = a[L-1:K] | b[L-1:K];
            end
        end else begin : g_exact
            assign carry_in = 1'b0;
        end

        if (L < N) begin : g_upper
            assign result_d[N:L] = UW'(a[N-1:L]) + UW'(b[N-1:L]) + UW'(carry_in);
        end else begin : g_no_upper
            assign result_d[N] = carry_in;
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_top.sv
// Directed and random self-checking bench for the OLOCA adder, four parameter sets on shared stimulus.
`timescale 1ns/1ps
module tb_top;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] res [4];
    logic        vld [4];

    int n_checks;
    int n_fail;

    int lp [4] = '{8, 0, 16, 6};
    int kp [4] = '{4, 0, 16, 3};

    top #(.N(16), .L(8),  .K(4))  dut     (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
                                           .out_valid(vld[0]), .result(res[0]));
    top #(.N(16), .L(0),  .K(0))  dut_l0  (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
                                           .out_valid(vld[1]), .result(res[1]));
    top #(.N(16), .L(16), .K(16)) dut_l16 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
                                           .out_valid(vld[2]), .result(res[2]));
    top #(.N(16), .L(6),  .K(3))  dut_l6  (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
                                           .out_valid(vld[3]), .result(res[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: exact upper sum shifted into place, then the lower bits overwritten.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input int l, input int k);
        logic [16:0] s;
        logic        c;
        int unsigned up;
        c = 1'b0;
`ifdef OLOCA_CARRY_EN
        if (l > 0) c = x[l-1] & y[l-1];
`endif
        up = (32'(x) >> l) + (32'(y) >> l) + 32'(c);
        s  = 17'(up << l);
        for (int i = 0; i < l; i++) s[i] = (i < k) ? 1'b1 : (x[i] | y[i]);
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        #1;
        n_checks++; if (res[0] !== 17'h0) begin n_fail++; $display("FAIL reset_result got %h want %h", res[0], 17'h0); end
        n_checks++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", vld[0]); end
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        n_checks++; if (res[0] !== 17'h0) begin n_fail++; $display("FAIL reset_hold_result got %h want %h", res[0], 17'h0); end
        n_checks++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid got %b want 0", vld[0]); end
        rst = 1'b0; a = 16'd2; b = 16'd1;
        @(posedge clk); #1;
        n_checks++; if (res[0] !== 17'h0000F) begin n_fail++; $display("FAIL small_result got %h want %h", res[0], 17'h0000F); end
        n_checks++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL small_valid got %b want 1", vld[0]); end
        a = 16'h1234; b = 16'h0101;
        #3 rst = 1'b1;
        #1;
        n_checks++; if (res[0] !== 17'h0) begin n_fail++; $display("FAIL async_reset_result got %h want %h", res[0], 17'h0); end
        n_checks++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got %b want 0", vld[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (res[0] !== 17'h0133F) begin n_fail++; $display("FAIL post_reset_result got %h want %h", res[0], 17'h0133F); end
        n_checks++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %b want 1", vld[0]); end
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h0002, 16'hFFFF, 16'h0100, 16'h00F0, 16'h0080};
        logic [15:0] vb [5] = '{16'h0001, 16'hFFFF, 16'h0100, 16'h000F, 16'h0080};
`ifdef OLOCA_CARRY_EN
        logic [16:0] ve [5] = '{17'h0000F, 17'h1FFFF, 17'h0020F, 17'h000FF, 17'h0018F};
`else
        logic [16:0] ve [5] = '{17'h0000F, 17'h1FEFF, 17'h0020F, 17'h000FF, 17'h0008F};
`endif
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i];
            @(posedge clk); #1;
            n_checks++;
            if (res[0] !== ve[i]) begin
                n_fail++; $display("FAIL directed_%0d a=%h b=%h got %h want %h", i, va[i], vb[i], res[0], ve[i]);
            end
            n_checks++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL directed_valid_%0d got %b want 1", i, vld[0]); end
        end
    endtask

    task automatic test_hold();
`ifdef OLOCA_CARRY_EN
        logic [16:0] held = 17'h0018F;
`else
        logic [16:0] held = 17'h0008F;
`endif
        in_valid = 1'b0; a = 16'h5555; b = 16'hAAAA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++; if (res[0] !== held) begin n_fail++; $display("FAIL hold_%0d got %h want %h", i, res[0], held); end
            n_checks++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL hold_valid_%0d got %b want 0", i, vld[0]); end
        end
    endtask

    task automatic test_degenerate();
`ifdef OLOCA_CARRY_EN
        logic [16:0] e_ones [4] = '{17'h1FFFF, 17'h1FFFE, 17'h1FFFF, 17'h1FFFF};
`else
        logic [16:0] e_ones [4] = '{17'h1FEFF, 17'h1FFFE, 17'h0FFFF, 17'h1FFBF};
`endif
        logic [16:0] e_mix [4] = '{17'h0133F, 17'h01335, 17'h0FFFF, 17'h01337};
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        for (int d = 1; d < 4; d++) begin
            n_checks++;
            if (res[d] !== e_ones[d]) begin n_fail++; $display("FAIL degen_ones_dut%0d got %h want %h", d, res[d], e_ones[d]); end
        end
        a = 16'h1234; b = 16'h0101;
        @(posedge clk); #1;
        for (int d = 1; d < 4; d++) begin
            n_checks++;
            if (res[d] !== e_mix[d]) begin n_fail++; $display("FAIL degen_mix_dut%0d got %h want %h", d, res[d], e_mix[d]); end
        end
    endtask

    task automatic test_random();
        logic [16:0] exp_r [4];
        logic        exp_v;
        for (int i = 0; i < 10000; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_v    = in_valid;
            if (in_valid) begin
                for (int d = 0; d < 4; d++) exp_r[d] = model(a, b, lp[d], kp[d]);
            end
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (res[d] !== exp_r[d]) begin
                    n_fail++; $display("FAIL random_result dut%0d cycle %0d got %h want %h", d, i, res[d], exp_r[d]);
                end
                n_checks++;
                if (vld[d] !== exp_v) begin
                    n_fail++; $display("FAIL random_valid dut%0d cycle %0d got %b want %b", d, i, vld[d], exp_v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_hold();
        test_degenerate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
